wb_selftest_master: RTL and testbench

//  Synthesizable Wishbone classic master that self-tests a Wishbone slave (e.g. wb_systolic_array).

---
 rtl/wb_selftest_master_if.sv | 26 ++
 rtl/wb_selftest_master.sv | 178 +++++++++++++++++
 tb/tb_wb_selftest_master.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_selftest_master_if.sv
// Wishbone classic bus bundle between the self-test master and the slave it exercises.
// Signal directions are named from the master's point of view.
interface wb_selftest_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    cyc_o;
    logic                    stb_o;
    logic                    we_o;
    logic [ADDR_WIDTH-1:0]   adr_o;
    logic [DATA_WIDTH-1:0]   dat_o;
    logic [DATA_WIDTH/8-1:0] sel_o;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic                    ack_i;
    logic                    err_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
        input  dat_i, ack_i, err_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
        output dat_i, ack_i, err_i
    );
endinterface

// File: rtl/wb_selftest_master.sv
// Wishbone classic master that resets a slave, writes a patterned block, reads it back and
// counts mismatches, bus errors and timeouts; can inject one slave reset mid-run.
module wb_selftest_master #(
    parameter int              ADDR_WIDTH = 32,
    parameter int              DATA_WIDTH = 32,
    parameter int              NUM_WORDS  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter logic [31:0]     SEED       = 32'hA5A5_0001,
    parameter logic [31:0]     STRIDE     = 32'h9E37_79B9,
    parameter int              RST_CYCLES = 100,
    parameter int              INJECT_AT  = 0,
    parameter int              TIMEOUT    = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        dut_rst_o,
    wb_selftest_master_if.master wb,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [15:0] err_cnt_o,
    output logic        inject_o
);

    localparam logic [DATA_WIDTH-1:0] SEED_D    = DATA_WIDTH'(SEED);
    localparam logic [DATA_WIDTH-1:0] STRIDE_D  = DATA_WIDTH'(STRIDE);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        IDLE,
        DUT_RST,
        WRITE,
        READ,
        DONE
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [31:0]           r_rstCnt;
    logic [31:0]           r_waitCnt;
    logic [31:0]           r_injCnt;
    logic [16:0]           r_wordIdx;
    logic [DATA_WIDTH-1:0] r_pattern;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [DATA_WIDTH-1:0] r_datO;
    logic                  r_cyc;
    logic                  r_we;
    logic [15:0]           r_errCnt;
    logic                  r_armed;
    logic                  r_cntRun;
    logic                  r_inject;

    logic w_inXfer;
    logic w_ack;
    logic w_busErr;
    logic w_timeout;
    logic w_xferDone;
    logic w_mismatch;
    logic w_errEvent;
    logic w_lastWord;
    logic w_rstDone;
    logic w_inject;
    logic w_startOk;

    // err_i wins over a simultaneous ack; a timeout is only declared when neither arrived.
    assign w_inXfer   = (r_state == WRITE) || (r_state == READ);
    assign w_busErr   = r_cyc & wb.err_i;
    assign w_ack      = r_cyc & wb.ack_i & ~wb.err_i;
    assign w_timeout  = r_cyc & ~wb.ack_i & ~wb.err_i & (r_waitCnt == 32'(TIMEOUT - 1));
    assign w_xferDone = w_ack | w_busErr | w_timeout;
    assign w_mismatch = w_ack & (r_state == READ) & (wb.dat_i != r_pattern);
    assign w_errEvent = w_busErr | w_timeout | w_mismatch;
    assign w_lastWord = (r_wordIdx == 17'(NUM_WORDS - 1));
    assign w_rstDone  = (r_rstCnt == 32'(RST_CYCLES - 1));
    assign w_startOk  = start_i && ((r_state == IDLE) || (r_state == DONE));
    assign w_inject   = r_armed && r_cntRun && (INJECT_AT != 0) &&
                        (r_injCnt == 32'(INJECT_AT)) && w_inXfer;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_rstCnt  <= '0;
            r_waitCnt <= '0;
            r_injCnt  <= '0;
            r_wordIdx <= '0;
            r_pattern <= SEED_D;
            r_adr     <= '0;
            r_datO    <= '0;
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_errCnt  <= '0;
            r_armed   <= 1'b1;
            r_cntRun  <= 1'b0;
            r_inject  <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_inject <= w_inject;
            r_rstCnt <= (r_state == DUT_RST) ? r_rstCnt + 32'd1 : 32'd0;

            // The injection timebase starts once, on the first time the slave leaves reset.
            if ((r_state == DUT_RST) && w_rstDone && !r_cntRun) begin
                r_cntRun <= 1'b1;
                r_injCnt <= '0;
            end else if (r_cntRun && r_armed) begin
                r_injCnt <= r_injCnt + 32'd1;
            end

            if (w_inject || ((r_state == READ) && (w_nextState == DONE)))
                r_armed <= 1'b0;

            if (w_inject || w_startOk)
                r_errCnt <= '0;
            else if (w_inXfer && w_errEvent && (r_errCnt != 16'hFFFF))
                r_errCnt <= r_errCnt + 16'd1;

            // Each word: one idle cycle to launch, then hold until ack/err/timeout.
            if (w_inject || !w_inXfer) begin
                r_cyc     <= 1'b0;
                r_we      <= 1'b0;
                r_wordIdx <= '0;
                r_pattern <= SEED_D;
            end else if (!r_cyc) begin
                r_cyc     <= 1'b1;
                r_we      <= (r_state == WRITE);
                r_adr     <= BASE_ADDR + ADDR_WIDTH'(r_wordIdx) * ADDR_STEP;
                r_datO    <= (r_state == WRITE) ? r_pattern : '0;
                r_waitCnt <= '0;
            end else if (w_xferDone) begin
                r_cyc <= 1'b0;
                r_we  <= 1'b0;
                if (w_lastWord) begin
                    r_wordIdx <= '0;
                    r_pattern <= SEED_D;
                end else begin
                    r_wordIdx <= r_wordIdx + 17'd1;
                    r_pattern <= r_pattern + STRIDE_D;
                end
            end else begin
                r_waitCnt <= r_waitCnt + 32'd1;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start_i) w_nextState = DUT_RST;
            DUT_RST: if (w_rstDone) w_nextState = WRITE;
            WRITE: begin
                if (w_inject)                      w_nextState = DUT_RST;
                else if (w_xferDone && w_lastWord) w_nextState = READ;
            end
            READ: begin
                if (w_inject)                      w_nextState = DUT_RST;
                else if (w_xferDone && w_lastWord) w_nextState = DONE;
            end
            DONE:    if (start_i) w_nextState = DUT_RST;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        dut_rst_o = (r_state == IDLE) || (r_state == DUT_RST);
        busy_o    = (r_state == DUT_RST) || w_inXfer;
        done_o    = (r_state == DONE);
        pass_o    = (r_state == DONE) && (r_errCnt == 16'd0);
        err_cnt_o = r_errCnt;
        inject_o  = r_inject;
        wb.cyc_o  = r_cyc;
        wb.stb_o  = r_cyc;
        wb.we_o   = r_we;
        wb.adr_o  = r_adr;
        wb.dat_o  = r_datO;
        wb.sel_o  = '1;
    end

endmodule

// File: tb/tb_wb_selftest_master.sv
// Directed bench: two masters (plain and with reset injection) against small behavioural
// Wishbone memories whose responses can be perturbed per test.
module tb_wb_selftest_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startA = 1'b0;
    logic        startB = 1'b0;
    logic        dutRstA, busyA, doneA, passA, injectA;
    logic        dutRstB, busyB, doneB, passB, injectB;
    logic [15:0] errA, errB;

    logic flipMode   = 1'b0;
    logic noAck8Mode = 1'b0;
    logic errW1Mode  = 1'b0;

    int checkCount = 0;
    int errCount   = 0;

    wb_selftest_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wbA ();
    wb_selftest_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wbB ();

    always #5 clk = ~clk;

    wb_selftest_master #(.NUM_WORDS(4), .TIMEOUT(8)) uDutA (
        .clk_i(clk), .rst_i(rst), .start_i(startA), .dut_rst_o(dutRstA), .wb(wbA),
        .busy_o(busyA), .done_o(doneA), .pass_o(passA), .err_cnt_o(errA), .inject_o(injectA)
    );

    wb_selftest_master #(.NUM_WORDS(4), .INJECT_AT(20)) uDutB (
        .clk_i(clk), .rst_i(rst), .start_i(startB), .dut_rst_o(dutRstB), .wb(wbB),
        .busy_o(busyB), .done_o(doneB), .pass_o(passB), .err_cnt_o(errB), .inject_o(injectB)
    );

    // Slave A: zero-latency memory with optional bit flip, missing ack, or bus error.
    logic [31:0] memA [0:3];
    logic        reqA;
    assign reqA      = wbA.cyc_o & wbA.stb_o;
    assign wbA.err_i = reqA & errW1Mode & wbA.we_o & (wbA.adr_o == 32'h4);
    assign wbA.ack_i = reqA & ~wbA.err_i & ~(noAck8Mode & (wbA.adr_o == 32'h8));
    assign wbA.dat_i = memA[wbA.adr_o[3:2]] ^ ((flipMode && (wbA.adr_o == 32'h8)) ? 32'h1 : 32'h0);

    always @(posedge clk)
        if (wbA.ack_i && wbA.we_o) memA[wbA.adr_o[3:2]] <= wbA.dat_o;

    // Slave B: memory that acknowledges in the third cycle of each strobe.
    logic [31:0] memB [0:3];
    logic [1:0]  latB = 2'd0;
    logic        reqB;
    assign reqB      = wbB.cyc_o & wbB.stb_o;
    assign wbB.ack_i = reqB & (latB == 2'd2);
    assign wbB.err_i = 1'b0;
    assign wbB.dat_i = memB[wbB.adr_o[3:2]];

    always @(posedge clk) begin
        latB <= (reqB && !wbB.ack_i) ? latB + 2'd1 : 2'd0;
        if (wbB.ack_i && wbB.we_o) memB[wbB.adr_o[3:2]] <= wbB.dat_o;
    end

    logic [31:0] logAdr [0:15];
    logic        logWe  [0:15];
    int          logN = 0;
    int          curHigh = 0;
    int          maxHigh = 0;
    int          doneRiseA = 0;
    logic        prevDoneA = 1'b0;
    int          injPulsesB = 0;
    int          rstLenB = 0;
    logic        measuringB = 1'b0;

    always @(negedge clk) begin
        if (reqA && (wbA.ack_i || wbA.err_i) && (logN < 16)) begin
            logAdr[logN] = wbA.adr_o;
            logWe[logN]  = wbA.we_o;
            logN++;
        end
        curHigh = wbA.cyc_o ? curHigh + 1 : 0;
        if (curHigh > maxHigh) maxHigh = curHigh;
        if (doneA && !prevDoneA) doneRiseA++;
        prevDoneA = doneA;
        if (injectB) begin
            injPulsesB++;
            measuringB = 1'b1;
            rstLenB    = 0;
        end
        if (measuringB) begin
            if (dutRstB) rstLenB++;
            else measuringB = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
    endtask

    task automatic waitDoneA(input int maxCyc, output int cyc);
        cyc = 0;
        while (!doneA && (cyc < maxCyc)) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("doneA_reached", 32'(doneA), 32'd1);
    endtask

    logic [31:0] expMem [0:3];
    int          cyc;

    initial begin
        expMem[0] = 32'hA5A5_0001;
        expMem[1] = 32'h43DC_79BA;
        expMem[2] = 32'hE213_F373;
        expMem[3] = 32'h804B_6D2C;

        repeat (3) @(negedge clk);
        checkOutput("rst_dut_rst", 32'(dutRstA), 32'd1);
        checkOutput("rst_cyc",     32'(wbA.cyc_o), 32'd0);
        checkOutput("rst_stb",     32'(wbA.stb_o), 32'd0);
        checkOutput("rst_we",      32'(wbA.we_o), 32'd0);
        checkOutput("rst_adr",     wbA.adr_o, 32'd0);
        checkOutput("rst_dat",     wbA.dat_o, 32'd0);
        checkOutput("rst_sel",     32'(wbA.sel_o), 32'hF);
        checkOutput("rst_busy",    32'(busyA), 32'd0);
        checkOutput("rst_done",    32'(doneA), 32'd0);
        checkOutput("rst_pass",    32'(passA), 32'd0);
        checkOutput("rst_err",     32'(errA), 32'd0);
        checkOutput("rst_inject",  32'(injectA), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_dut_rst", 32'(dutRstA), 32'd1);
        checkOutput("idle_busy",    32'(busyA), 32'd0);

        $display("[TB] test 1: clean run");
        logN = 0;
        maxHigh = 0;
        applyStimulus();
        checkOutput("t1_busy", 32'(busyA), 32'd1);
        checkOutput("t1_dut_rst", 32'(dutRstA), 32'd1);
        waitDoneA(1000, cyc);
        checkOutput("t1_cycles", 32'(cyc), 32'd116);
        checkOutput("t1_pass", 32'(passA), 32'd1);
        checkOutput("t1_err", 32'(errA), 32'd0);
        checkOutput("t1_busy_end", 32'(busyA), 32'd0);
        checkOutput("t1_dut_rst_end", 32'(dutRstA), 32'd0);
        checkOutput("t1_log_n", 32'(logN), 32'd8);
        checkOutput("t1_max_high", 32'(maxHigh), 32'd1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t1_adr%0d", i), logAdr[i], 32'((i % 4) * 4));
            checkOutput($sformatf("t1_we%0d", i), 32'(logWe[i]), (i < 4) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t1_mem%0d", i), memA[i], expMem[i]);

        $display("[TB] test 2: bit flip on word 2");
        flipMode = 1'b1;
        applyStimulus();
        checkOutput("t2_done_cleared", 32'(doneA), 32'd0);
        checkOutput("t2_err_cleared", 32'(errA), 32'd0);
        waitDoneA(1000, cyc);
        checkOutput("t2_cycles", 32'(cyc), 32'd116);
        checkOutput("t2_pass", 32'(passA), 32'd0);
        checkOutput("t2_err", 32'(errA), 32'd1);
        flipMode = 1'b0;

        $display("[TB] test 3: address 8 never acknowledged");
        noAck8Mode = 1'b1;
        maxHigh = 0;
        applyStimulus();
        waitDoneA(1000, cyc);
        checkOutput("t3_cycles", 32'(cyc), 32'd130);
        checkOutput("t3_max_high", 32'(maxHigh), 32'd8);
        checkOutput("t3_pass", 32'(passA), 32'd0);
        checkOutput("t3_err", 32'(errA), 32'd2);
        noAck8Mode = 1'b0;

        $display("[TB] test 5: bus error on word 1 write, start while busy");
        errW1Mode = 1'b1;
        applyStimulus();
        doneRiseA = 0;
        cyc = 0;
        while (!wbA.cyc_o && (cyc < 300)) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t5_cyc_seen", 32'(wbA.cyc_o), 32'd1);
        applyStimulus();
        checkOutput("t5_busy_after_start", 32'(busyA), 32'd1);
        waitDoneA(1000, cyc);
        checkOutput("t5_err", 32'(errA), 32'd1);
        repeat (20) @(negedge clk);
        checkOutput("t5_done_held", 32'(doneA), 32'd1);
        checkOutput("t5_done_rises", 32'(doneRiseA), 32'd1);
        checkOutput("t5_err_held", 32'(errA), 32'd1);
        errW1Mode = 1'b0;

        $display("[TB] test 6: reset during read");
        noAck8Mode = 1'b1;
        applyStimulus();
        cyc = 0;
        while (!(wbA.cyc_o && !wbA.we_o && (wbA.adr_o == 32'h8)) && (cyc < 300)) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t6_read8_seen", 32'(wbA.cyc_o && !wbA.we_o), 32'd1);
        checkOutput("t6_err_before", 32'(errA), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_cyc", 32'(wbA.cyc_o), 32'd0);
        checkOutput("t6_stb", 32'(wbA.stb_o), 32'd0);
        checkOutput("t6_dut_rst", 32'(dutRstA), 32'd1);
        checkOutput("t6_err", 32'(errA), 32'd0);
        checkOutput("t6_busy", 32'(busyA), 32'd0);
        checkOutput("t6_done", 32'(doneA), 32'd0);
        rst = 1'b0;
        noAck8Mode = 1'b0;
        @(negedge clk);
        applyStimulus();
        waitDoneA(1000, cyc);
        checkOutput("t6_cycles", 32'(cyc), 32'd116);
        checkOutput("t6_pass", 32'(passA), 32'd1);
        checkOutput("t6_err_end", 32'(errA), 32'd0);

        $display("[TB] test 4: reset injection at 20");
        injPulsesB = 0;
        startB = 1'b1;
        @(negedge clk);
        startB = 1'b0;
        cyc = 0;
        while (!doneB && (cyc < 1000)) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t4_done", 32'(doneB), 32'd1);
        checkOutput("t4_cycles", 32'(cyc), 32'd253);
        checkOutput("t4_inject_pulses", 32'(injPulsesB), 32'd1);
        checkOutput("t4_rst_len", 32'(rstLenB), 32'd100);
        checkOutput("t4_pass", 32'(passB), 32'd1);
        checkOutput("t4_err", 32'(errB), 32'd0);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t4_mem%0d", i), memB[i], expMem[i]);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
